// File: rtl/rf_stream_fifo.sv
// Streaming FIFO built on an external two-port register file with 1-cycle read latency.
// A 3-entry skid buffer prefetches RF words so the consumer can pop every cycle.
module rf_stream_fifo #(
    parameter int WORDS = 12,
    parameter int DWd   = 32,
    parameter int AWd   = $clog2(WORDS),
    parameter int LWd   = $clog2(WORDS + 4)
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [DWd-1:0] i_data,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [DWd-1:0] o_data,
    output logic           o_rf_write,
    output logic [AWd-1:0] o_rf_waddr,
    output logic [DWd-1:0] o_rf_wdata,
    output logic           o_rf_re,
    output logic [AWd-1:0] o_rf_raddr,
    input  logic [DWd-1:0] i_rf_rdata,
    output logic [LWd-1:0] o_level,
    output logic           o_empty
);

    localparam int CWd = $clog2(WORDS + 1);
    localparam logic [AWd-1:0] LAST = AWd'(WORDS - 1);

    logic [AWd-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CWd-1:0] rf_cnt_q, rf_cnt_d;
    logic           inflight_q;
    logic [1:0]     skid_cnt_q, skid_cnt_d;
    logic [DWd-1:0] skid_q [3];
    logic [DWd-1:0] skid_d [3];
    logic           ready_q, ready_d;
    logic           push, issue, pop;

    assign push  = i_valid & ready_q;
    // Credit check uses registered state only; a same-cycle pop does not free a slot.
    assign issue = (rf_cnt_q != '0) &&
                   (({1'b0, skid_cnt_q} + {2'b00, inflight_q}) < 3'd3);
    assign pop   = (skid_cnt_q != 2'd0) & i_ready;

    assign o_ready    = ready_q;
    assign o_rf_write = push;
    assign o_rf_waddr = wptr_q;
    assign o_rf_wdata = i_data;
    assign o_rf_re    = issue;
    assign o_rf_raddr = rptr_q;
    assign o_valid    = (skid_cnt_q != 2'd0);
    assign o_data     = skid_q[0];
    assign o_level    = LWd'(rf_cnt_q) + LWd'(inflight_q) + LWd'(skid_cnt_q);
    assign o_empty    = (o_level == '0);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        if (push) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + AWd'(1);
        if (issue) rptr_d = (rptr_q == LAST) ? '0 : rptr_q + AWd'(1);
        rf_cnt_d = rf_cnt_q + CWd'(push) - CWd'(issue);
        ready_d  = (rf_cnt_d < CWd'(WORDS));

        // Pop first, then the returning RF word lands behind whatever remains.
        if (pop) begin
            skid_d[0]  = skid_q[1];
            skid_d[1]  = skid_q[2];
            skid_cnt_d = skid_cnt_q - 2'd1;
        end
        if (inflight_q) begin
            case (skid_cnt_d)
                2'd0:    skid_d[0] = i_rf_rdata;
                2'd1:    skid_d[1] = i_rf_rdata;
                default: skid_d[2] = i_rf_rdata;
            endcase
            skid_cnt_d = skid_cnt_d + 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rf_cnt_q   <= '0;
            inflight_q <= 1'b0;
            skid_cnt_q <= 2'd0;
            ready_q    <= 1'b0;
            for (int i = 0; i < 3; i++) skid_q[i] <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rf_cnt_q   <= rf_cnt_d;
            inflight_q <= issue;
            skid_cnt_q <= skid_cnt_d;
            ready_q    <= ready_d;
            for (int i = 0; i < 3; i++) skid_q[i] <= skid_d[i];
        end
    end

endmodule

// File: tb/tb_rf_stream_fifo.sv
// Directed + random bench for rf_stream_fifo with an RF model and a queue-based reference.
module tb_rf_stream_fifo;

    localparam int WORDS = 12;
    localparam int DWd   = 32;
    localparam int AWd   = $clog2(WORDS);
    localparam int LWd   = $clog2(WORDS + 4);

    logic           i_clk = 1'b0;
    logic           i_rstn = 1'b0;
    logic           i_valid, o_ready, o_valid, i_ready;
    logic [DWd-1:0] i_data, o_data, o_rf_wdata, i_rf_rdata;
    logic           o_rf_write, o_rf_re, o_empty;
    logic [AWd-1:0] o_rf_waddr, o_rf_raddr;
    logic [LWd-1:0] o_level;

    rf_stream_fifo #(.WORDS(WORDS), .DWd(DWd)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_rf_write(o_rf_write), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .o_rf_re(o_rf_re), .o_rf_raddr(o_rf_raddr), .i_rf_rdata(i_rf_rdata),
        .o_level(o_level), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [DWd-1:0] q[$];
    logic [DWd-1:0] mem [WORDS];
    int             wcnt, rcnt, rf_occ;
    logic [DWd-1:0] rdata_next;
    logic           rdata_vld;
    logic           prev_stall;
    logic [DWd-1:0] prev_data;

    logic           s_we, s_re, s_valid, s_ready, s_push, s_pop, s_empty;
    logic [AWd-1:0] s_waddr, s_raddr;
    logic [DWd-1:0] s_data;
    logic [LWd-1:0] s_level;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcnt = 0; rcnt = 0; rf_occ = 0;
        prev_stall = 1'b0; prev_data = '0;
        rdata_vld = 1'b0; rdata_next = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_level"}, o_level, 0);
        chk({tag, "_empty"}, o_empty, 1);
        chk({tag, "_we"},    o_rf_write, 0);
        chk({tag, "_re"},    o_rf_re, 0);
        chk({tag, "_data"},  o_data, 0);
    endtask

    // One clock cycle: drive at posedge+1, check and update the model at negedge.
    task automatic cycle(input logic v, input logic [DWd-1:0] d, input logic r);
        i_valid = v; i_data = d; i_ready = r;
        @(negedge i_clk);
        s_we = o_rf_write; s_re = o_rf_re; s_valid = o_valid; s_ready = o_ready;
        s_waddr = o_rf_waddr; s_raddr = o_rf_raddr; s_data = o_data;
        s_level = o_level; s_empty = o_empty;
        s_push = i_valid & o_ready;
        s_pop  = o_valid & i_ready;

        chk("level", o_level, q.size());
        chk("empty", o_empty, q.size() == 0);
        chk("we_is_push", o_rf_write, s_push);
        if (q.size() >= WORDS + 3) chk("full_ready", o_ready, 0);
        if (o_valid) begin
            chk("valid_has_data", q.size() > 0, 1);
            if (q.size() > 0) chk("head_data", o_data, q[0]);
        end
        if (prev_stall) begin
            chk("stall_valid", o_valid, 1);
            chk("stall_data", o_data, prev_data);
        end
        if (o_rf_write) begin
            chk("waddr", o_rf_waddr, wcnt % WORDS);
            chk("wdata", o_rf_wdata, d);
        end
        if (o_rf_re) begin
            chk("re_rf_nonempty", rf_occ > 0, 1);
            chk("raddr", o_rf_raddr, rcnt % WORDS);
        end

        prev_stall = o_valid & ~i_ready;
        prev_data  = o_data;
        rdata_vld  = o_rf_re;
        if (o_rf_re) begin
            rdata_next = (int'(o_rf_raddr) < WORDS) ? mem[o_rf_raddr] : 'x;
            rcnt++; rf_occ--;
        end
        if (o_rf_write) begin
            if (int'(o_rf_waddr) < WORDS) mem[o_rf_waddr] = i_data;
            wcnt++; rf_occ++;
        end
        if (s_push) q.push_back(d);
        if (s_pop && q.size() > 0) void'(q.pop_front());
        @(posedge i_clk);
        #1;
        i_rf_rdata = rdata_vld ? rdata_next : $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc;
        i_valid = 1'b0; i_ready = 1'b0; i_data = '0; i_rf_rdata = '0;
        model_reset();

        #12;
        chk_reset_outputs("rst");
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(posedge i_clk);
        #1;

        // Single word latency
        cycle(1'b1, 32'hA5A5_0001, 1'b1);
        chk("t1_ready_c0", s_ready, 1);
        chk("t1_we_c0", s_we, 1);
        chk("t1_waddr_c0", s_waddr, 0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_re_c1", s_re, 1);
        chk("t1_raddr_c1", s_raddr, 0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_valid_c2", s_valid, 0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_valid_c3", s_valid, 1);
        chk("t1_data_c3", s_data, 32'hA5A5_0001);
        cycle(1'b0, '0, 1'b1);
        chk("t1_empty_c4", s_empty, 1);

        // Fill to capacity with the consumer stalled, then drain without gaps
        n = 0;
        for (int i = 0; i < 25; i++) begin
            cycle(1'b1, DWd'(n), 1'b0);
            if (s_push) n++;
        end
        chk("t2_accepted", n, WORDS + 3);
        chk("t2_ready_low", o_ready, 0);
        chk("t2_level", o_level, WORDS + 3);
        for (int i = 0; i < WORDS + 3; i++) begin
            cycle(1'b0, '0, 1'b1);
            chk("t2_nogap", s_valid, 1);
        end
        chk("t2_drained", q.size(), 0);

        // Continuous streaming
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, DWd'(1000 + i), 1'b1);
            chk("t3_accept", s_push, 1);
            if (i >= 4) chk("t3_level_le3", s_level <= 3, 1);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
        chk("t3_drained", q.size(), 0);

        // Random traffic
        n = 0;
        for (int c = 0; c < 20000 && n < 1000; c++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            if (s_push) n++;
        end
        chk("t4_pushed", n, 1000);
        for (int c = 0; c < 100 && q.size() > 0; c++) cycle(1'b0, '0, 1'b1);
        chk("t4_drained", q.size(), 0);

        // Reset mid-stream
        for (int i = 0; i < 8; i++) cycle(1'b1, DWd'(32'h500 + i), 1'b0);
        chk("t5_level_before", o_level, 8);
        #2;
        i_rstn = 1'b0;
        #1;
        chk_reset_outputs("t5_async");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rstn = 1'b1;
        model_reset();
        @(posedge i_clk);
        #1;
        chk("t5_ready_after", o_ready, 1);
        cycle(1'b1, 32'h1234, 1'b1);
        chk("t5_we", s_we, 1);
        chk("t5_waddr", s_waddr, 0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        chk("t5_valid_c3", s_valid, 1);
        chk("t5_data_c3", s_data, 32'h1234);
        cycle(1'b0, '0, 1'b1);

        // Full FIFO: push attempt coinciding with a pop is refused, then retried
        for (int i = 0; i < 30 && q.size() < WORDS + 3; i++) cycle(1'b1, DWd'(32'h600 + i), 1'b0);
        chk("t6_full", q.size(), WORDS + 3);
        cycle(1'b1, 32'h7777, 1'b1);
        chk("t6_refused_ready", s_ready, 0);
        chk("t6_refused_push", s_push, 0);
        chk("t6_popped", s_pop, 1);
        acc = 0;
        for (int i = 0; i < 6 && acc == 0; i++) begin
            cycle(1'b1, 32'h7777, 1'b0);
            if (s_push) acc = 1;
        end
        chk("t6_accepted", acc, 1);
        for (int c = 0; c < 50 && q.size() > 0; c++) cycle(1'b0, '0, 1'b1);
        chk("t6_drained", q.size(), 0);
        chk("t6_empty", o_empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
